// File: rtl/fp_pkg.sv
// Shared definitions for the fp32 datapath: field positions, exponent landmarks,
// integer saturation limits and the enums used by the float-to-int converter.
package fp_pkg;

  localparam int SIGN_BIT  = 31;
  localparam int EXP_MSB   = 30;
  localparam int EXP_LSB   = 23;
  localparam int FRAC_W    = 23;

  localparam int BIAS      = 127;
  localparam int ALIGN_EXP = 150;
  localparam int OVF_EXP   = 158;

  localparam logic [31:0] INT_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;
  localparam logic [31:0] FP_NEG_2P31 = 32'hCF00_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_UNDER,
    CLS_INTMIN,
    CLS_OVER,
    CLS_NORMAL
  } fp_class_t;

  typedef enum logic {
    DIR_RIGHT,
    DIR_LEFT
  } shift_dir_t;

  function automatic logic [31:0] saturate(input logic sign);
    return sign ? INT_MIN : INT_MAX;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier: sorts an fp32 operand into its conversion case and
// derives the alignment shift direction and distance used for normal values.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] i_a,
  output fp_class_t   o_class,
  output shift_dir_t  o_dir,
  output logic [4:0]  o_cnt
);

  logic [7:0]        w_exp;
  logic [FRAC_W-1:0] w_frac;

  assign w_exp  = i_a[EXP_MSB:EXP_LSB];
  assign w_frac = i_a[FRAC_W-1:0];

  // -2^31 is representable exactly, so it is tested before the overflow range.
  always_comb begin
    o_class = CLS_NORMAL;
    if (w_exp == 8'd0 && w_frac == '0) begin
      o_class = CLS_ZERO;
    end else if (w_exp < 8'(BIAS)) begin
      o_class = CLS_UNDER;
    end else if (i_a == FP_NEG_2P31) begin
      o_class = CLS_INTMIN;
    end else if (w_exp >= 8'(OVF_EXP)) begin
      o_class = CLS_OVER;
    end
  end

  always_comb begin
    if (w_exp >= 8'(ALIGN_EXP)) begin
      o_dir = DIR_LEFT;
      o_cnt = 5'(w_exp - 8'(ALIGN_EXP));
    end else begin
      o_dir = DIR_RIGHT;
      o_cnt = 5'(8'(ALIGN_EXP) - w_exp);
    end
  end

endmodule

// File: rtl/fp_to_int.sv
// Sequential fp32 to signed int32 converter (truncate toward zero) with a
// one-bit-per-cycle alignment shifter behind valid/ready handshakes.
module fp_to_int
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflag,
  output logic        underflag
);

  state_t     r_state;
  state_t     w_next_state;
  fp_class_t  w_class;
  shift_dir_t w_dir;
  logic [4:0] w_cnt;
  logic       w_accept;

  logic [31:0] r_mag;
  logic [4:0]  r_cnt;
  shift_dir_t  r_dir;
  logic        r_sign;
  logic [31:0] r_result;
  logic        r_over;
  logic        r_under;

  fp_classify u_classify (
    .i_a     (A),
    .o_class (w_class),
    .o_dir   (w_dir),
    .o_cnt   (w_cnt)
  );

  assign w_accept = in_valid && (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_next_state = (w_class == CLS_NORMAL) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == 5'd0) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  // Special cases resolve at accept; normal values finish after the shift walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag    <= '0;
      r_cnt    <= '0;
      r_dir    <= DIR_RIGHT;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_over   <= 1'b0;
      r_under  <= 1'b0;
    end else if (w_accept) begin
      r_sign   <= A[SIGN_BIT];
      r_result <= '0;
      r_over   <= 1'b0;
      r_under  <= 1'b0;
      case (w_class)
        CLS_UNDER:  r_under <= 1'b1;
        CLS_INTMIN: r_result <= INT_MIN;
        CLS_OVER: begin
          r_over   <= 1'b1;
          r_result <= saturate(A[SIGN_BIT]);
        end
        CLS_NORMAL: begin
          r_mag <= {8'd0, 1'b1, A[FRAC_W-1:0]};
          r_cnt <= w_cnt;
          r_dir <= w_dir;
        end
        default: ;
      endcase
    end else if (r_state == ST_SHIFT) begin
      if (r_cnt != 5'd0) begin
        r_mag <= (r_dir == DIR_LEFT) ? {r_mag[30:0], 1'b0} : {1'b0, r_mag[31:1]};
        r_cnt <= r_cnt - 5'd1;
      end else begin
        r_result <= r_sign ? (~r_mag + 32'd1) : r_mag;
      end
    end
  end

  assign result    = r_result;
  assign overflag  = r_over;
  assign underflag = r_under;

endmodule
